// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode encodings, FSM state type,
// iteration-counter width helper and the iterative-opcode classifier.
// Pure declarations; no clocked logic, no handshake.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_REMU  = 4'b1100;
    localparam logic [3:0] OP_SRA   = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so log2(WIDTH) bits suffice.
    function automatic int iter_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Latency: operands captured on start edge, WIDTH iteration edges; done is high during the last one.
// No backpressure: once started it runs to completion; the parent never restarts it mid-run.
// Ports: start/op/A/B in; done (last iteration this cycle) and result (value after that iteration) out.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int             CW   = iter_cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic             running;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;       // product high half / partial remainder
    logic [WIDTH-1:0] lo;       // multiplier bits / dividend shifting into quotient
    logic [WIDTH-1:0] b_q;      // multiplicand / divisor
    logic             is_div;
    logic             hi_sel;   // MULHU and REMU take the high register

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        hi_n      = mul_sum[WIDTH:1];
        lo_n      = {mul_sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            // A zero divisor never borrows, which naturally yields an all-ones
            // quotient and leaves the dividend as the remainder.
            if (!div_diff[WIDTH]) begin
                hi_n = div_diff[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = div_shift[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign done   = running && (cnt == LAST);
    assign result = hi_sel ? hi_n : lo_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            b_q     <= '0;
            is_div  <= 1'b0;
            hi_sel  <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            hi      <= '0;
            lo      <= A;
            b_q     <= B;
            is_div  <= (op == OP_DIVU) || (op == OP_REMU);
            hi_sel  <= (op == OP_MULHU) || (op == OP_REMU);
        end else if (running) begin
            hi <= hi_n;
            lo <= lo_n;
            if (cnt == LAST) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// ALU with valid/ready handshake: single-cycle logic/arith/shift ops plus optional iterative mul/div.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/MULHU/DIVU/REMU.
// Backpressure: result held in DONE until out_ready; in_ready low in BUSY and in DONE without out_ready.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/A/B/ALU_Control in;
//        out_valid/out_ready/ALU_Result/Zero out; Busy flags an iterative op in flight.
// Build option: define ALU_MULDIV_EN to include the iterative datapath; otherwise
//               opcodes 1001-1100 complete in one cycle with result 0 and Busy is tied low.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Result,
    output logic             Zero,
    output logic             Busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_n;
    logic             accept;
    logic             iter_op;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [SHW-1:0]   shamt;

    assign shamt  = B[SHW-1:0];
    assign accept = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
    assign iter_op = is_muldiv_op(ALU_Control);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && iter_op),
        .op     (ALU_Control),
        .A      (A),
        .B      (B),
        .done   (iter_done),
        .result (iter_result)
    );
`else
    assign iter_op     = 1'b0;
    assign iter_done   = 1'b0;
    assign iter_result = '0;
`endif

    // Single-cycle datapath; mul/div codes fall to the default and give 0.
    always_comb begin
        alu_res = '0;
        case (ALU_Control)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:  alu_res = A << shamt;
            OP_SRL:  alu_res = A >> shamt;
            OP_SRA:  alu_res = $signed(A) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; DONE can accept the next op on the transfer edge.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_n = iter_op ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (iter_done) state_n = ST_DONE;
            end
            ST_DONE: begin
                if (accept)         state_n = iter_op ? ST_BUSY : ST_DONE;
                else if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
        out_valid = (state == ST_DONE);
`ifdef ALU_MULDIV_EN
        Busy      = (state == ST_BUSY);
`else
        Busy      = 1'b0;
`endif
    end

    // Result register: loaded at the handshake for single-cycle ops, or on the
    // final iteration edge; otherwise held so DONE presents a stable value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (accept && !iter_op) begin
            result_q <= alu_res;
            zero_q   <= (alu_res == '0);
        end else if ((state == ST_BUSY) && iter_done) begin
            result_q <= iter_result;
            zero_q   <= (iter_result == '0);
        end
    end

    assign ALU_Result = result_q;
    assign Zero       = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32.
// Expected values follow the build: with ALU_MULDIV_EN the mul/div ops are iterative,
// otherwise they complete in one cycle with result 0.
module tb_alu_multicycle;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    localparam logic [3:0] C_AND   = 4'b0000;
    localparam logic [3:0] C_OR    = 4'b0001;
    localparam logic [3:0] C_ADD   = 4'b0010;
    localparam logic [3:0] C_XOR   = 4'b0011;
    localparam logic [3:0] C_SLL   = 4'b0100;
    localparam logic [3:0] C_SRL   = 4'b0101;
    localparam logic [3:0] C_SUB   = 4'b0110;
    localparam logic [3:0] C_SLT   = 4'b0111;
    localparam logic [3:0] C_SLTU  = 4'b1000;
    localparam logic [3:0] C_MUL   = 4'b1001;
    localparam logic [3:0] C_MULHU = 4'b1010;
    localparam logic [3:0] C_DIVU  = 4'b1011;
    localparam logic [3:0] C_REMU  = 4'b1100;
    localparam logic [3:0] C_SRA   = 4'b1101;

    localparam int ITER_LAT = MD ? 33 : 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_Control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALU_Result;
    logic        Zero;
    logic        Busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .ALU_Control (ALU_Control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_Result  (ALU_Result),
        .Zero        (Zero),
        .Busy        (Busy)
    );

    // Issue one op from IDLE, wait (bounded) for out_valid, capture, then drain.
    // With poke set, a stray in_valid is driven while the op is in flight.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, output logic [31:0] res, output logic z,
                          output int lat, output bit rdy_seen, output bit busy_seen);
        ALU_Control = op;
        A           = a;
        B           = b;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        A         = 32'hDEAD_BEEF;
        B         = 32'h0000_0003;
        lat       = 1;
        rdy_seen  = 1'b0;
        busy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            if (Busy) busy_seen = 1'b1;
            in_valid    = poke;
            ALU_Control = C_SUB;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        res      = ALU_Result;
        z        = Zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", Busy); end
        checks++; if (ALU_Result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=0", ALU_Result); end
        checks++; if (Zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b want=1", Zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_cycle();
        logic [3:0]  ops  [14];
        logic [31:0] as   [14];
        logic [31:0] bs   [14];
        logic [31:0] exps [14];
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          rs, bsy;
        ops  = '{C_ADD, C_SLT, C_SLTU, C_SRA, C_SRA, C_AND, C_OR, C_XOR,
                 C_SUB, C_SLL, C_SRL, C_SLT, C_SLTU, 4'b1110};
        as   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0001,
                 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0005};
        bs   = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_001F, 32'h0000_0024,
                 32'hFF00_FF00, 32'h0F0F_0000, 32'hFF00_FF00, 32'h0000_0001, 32'h0000_003F,
                 32'h0000_0004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0006};
        exps = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hF800_0000,
                 32'hF000_F000, 32'hFFFF_F0F0, 32'h00FF_FF00, 32'hFFFF_FFFF, 32'h8000_0000,
                 32'h0800_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000};
        for (int i = 0; i < 14; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, res, z, lat, rs, bsy);
            checks++;
            if (res !== exps[i]) begin
                failures++;
                $display("FAIL single_result[%0d] op=%b got=%h want=%h", i, ops[i], res, exps[i]);
            end
            checks++;
            if (z !== (exps[i] == 32'h0)) begin
                failures++;
                $display("FAIL single_zero[%0d] got=%b want=%b", i, z, (exps[i] == 32'h0));
            end
            checks++;
            if (lat != 1) begin
                failures++;
                $display("FAIL single_latency[%0d] got=%0d want=1", i, lat);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  ops  [8];
        logic [31:0] as   [8];
        logic [31:0] bs   [8];
        logic [31:0] exps [8];
        logic [31:0] want;
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          rs, bsy;
        ops  = '{C_MUL, C_MULHU, C_MUL, C_MULHU, C_DIVU, C_REMU, C_DIVU, C_REMU};
        as   = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'd7, 32'd7, 32'd100, 32'd100};
        bs   = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'd0, 32'd0, 32'd7, 32'd7};
        exps = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFE,
                 32'hFFFF_FFFF, 32'd7, 32'd14, 32'd2};
        for (int i = 0; i < 8; i++) begin
            want = MD ? exps[i] : 32'h0;
            run_op(ops[i], as[i], bs[i], 1'b0, res, z, lat, rs, bsy);
            checks++;
            if (res !== want) begin
                failures++;
                $display("FAIL muldiv_result[%0d] op=%b got=%h want=%h", i, ops[i], res, want);
            end
            checks++;
            if (lat != ITER_LAT) begin
                failures++;
                $display("FAIL muldiv_latency[%0d] got=%0d want=%0d", i, lat, ITER_LAT);
            end
            checks++;
            if (rs !== 1'b0) begin
                failures++;
                $display("FAIL muldiv_in_ready_busy[%0d] got=%b want=0", i, rs);
            end
            checks++;
            if (bsy !== MD) begin
                failures++;
                $display("FAIL muldiv_busy_flag[%0d] got=%b want=%b", i, bsy, MD);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          rs, bsy;
        run_op(C_DIVU, 32'd100, 32'd7, 1'b1, res, z, lat, rs, bsy);
        checks++;
        if (res !== (MD ? 32'd14 : 32'd0)) begin
            failures++;
            $display("FAIL busy_ignore_result got=%h want=%h", res, (MD ? 32'd14 : 32'd0));
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_no_extra got=%b want=0", out_valid);
        end
    endtask

    task automatic test_hold();
        ALU_Control = C_ADD;
        A           = 32'd5;
        B           = 32'd3;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || ALU_Result !== 32'd8) begin
            failures++;
            $display("FAIL hold_first got_valid=%b got=%h want_valid=1 want=8", out_valid, ALU_Result);
        end
        ALU_Control = C_SUB;
        A           = 32'd1;
        B           = 32'd1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_in_ready[%0d] got=%b want=0", c, in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (ALU_Result !== 32'd8 || Zero !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable[%0d] got=%h zero=%b valid=%b want=8 zero=0 valid=1",
                         c, ALU_Result, Zero, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        ALU_Control = C_ADD;
        A           = 32'd10;
        B           = 32'd20;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_in_ready got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ALU_Result !== 32'd30) begin
            failures++;
            $display("FAIL b2b_next_result valid=%b got=%h want_valid=1 want=1e", out_valid, ALU_Result);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drained got=%b want=0", out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        ALU_Control = MD ? C_DIVU : C_ADD;
        A           = MD ? 32'd100 : 32'd2;
        B           = MD ? 32'd7 : 32'd2;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (Busy !== MD) begin
            failures++;
            $display("FAIL midrst_busy_before got=%b want=%b", Busy, MD);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Busy !== 1'b0 ||
            ALU_Result !== 32'h0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL midrst_outputs rdy=%b vld=%b busy=%b res=%h zero=%b want 1 0 0 0 1",
                     in_ready, out_valid, Busy, ALU_Result, Zero);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_result got=%b want=0", seen);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_idle got=%b want=1", in_ready);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        A           = '0;
        B           = '0;
        ALU_Control = '0;
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_busy_ignore();
        test_hold();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "simulation time limit reached");
    end

endmodule
